// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one add/subtract datapath among NUM_REQ requesters.
// One operation in flight at a time; the result returns on a valid/ready channel tagged by id.
module alu_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_op,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic                       alu_sel,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant;
    logic              grant_vld;
    logic [ID_W:0]     idx;
    logic [CNT_W-1:0]  cnt;
    logic              handshake;

    // Search starts one past the last winner; the extra idx bit absorbs the wrap before folding.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_grant} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(NUM_REQ)) begin
                idx = idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid[idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is masked by reset so every output is quiet while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld && !reset) begin
                    req_ready[grant] = 1'b1;
                    handshake        = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Operand registers double as the datapath drive and hold until the next handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
        end else begin
            if (handshake) begin
                last_grant <= grant;
                rsp_id     <= grant;
                alu_a      <= req_a[grant*WIDTH +: WIDTH];
                alu_b      <= req_b[grant*WIDTH +: WIDTH];
                alu_sel    <= req_op[grant];
                cnt        <= CNT_W'(ALU_LATENCY);
            end
            if (state == EXEC) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    rsp_data <= alu_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a one-cycle registered add/sub datapath model.
// Driver pushes hand-computed expectations at each handshake; a monitor pops on response accept.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_sel;
    logic [7:0]  alu_result = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         hs_cyc;
    } exp_t;

    exp_t sbq[$];

    alu_share_arbiter #(.NUM_REQ(4), .WIDTH(8), .ALU_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        alu_result <= alu_sel ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks id, data and first-rise latency on every accepted response.
    initial begin
        bit prev_valid = 1'b0;
        int rise_cyc   = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid && !prev_valid) rise_cyc = cyc;
            if (!reset && rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_id", {30'd0, rsp_id}, e.id);
                    chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                    chk("rsp_latency", rise_cyc - e.hs_cyc, 3);
                end
            end
            prev_valid = !reset && rsp_valid;
        end
    end

    task automatic drain(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sbq.size() != 0) && n < 50);
        chk({name, "_drain"}, {31'd0, (busy || sbq.size() != 0)}, 32'd0);
    endtask

    task automatic issue(input int id, input logic op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp, input string name);
        int w   = 0;
        bit got = 1'b0;
        @(posedge clk); #1;
        req_op[id]       = op;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid[id]    = 1'b1;
        while (!got && w < 30) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
            else w++;
        end
        chk({name, "_ready"}, {28'd0, req_ready}, 32'(1) << id);
        chk({name, "_wait"}, w, 0);
        if (got) sbq.push_back('{id, exp, cyc});
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    initial begin
        int seq[6]      = '{0, 1, 2, 3, 0, 1};
        logic [7:0] fexp[4] = '{8'h42, 8'hF0, 8'h10, 8'h00};
        int k, n, last, h;

        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[6]          = '{0, 1, 2, 3, 0, 1};
        logic [7:0] fexp[4] = '{8'h42, 8'hF0, 8'h10, 8'h00};
        int k, n, last;

        reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {28'd0, req_ready}, 0);
        chk("rst_alu_a", {24'd0, alu_a}, 0);
        chk("rst_alu_b", {24'd0, alu_b}, 0);
        chk("rst_alu_sel", {31'd0, alu_sel}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        rsp_ready = 1'b1;

        // Single add, subtract wrap, add wrap
        issue(0, 1'b0, 8'h10, 8'h05, 8'h15, "add");
        drain("add");
        issue(1, 1'b1, 8'h03, 8'h05, 8'hFE, "sub_wrap");
        drain("sub_wrap");
        issue(2, 1'b0, 8'hFF, 8'h01, 8'h00, "add_wrap");
        drain("add_wrap");

        // Sparse: each single requester granted on its first valid IDLE cycle
        issue(2, 1'b1, 8'h20, 8'h01, 8'h1F, "sparse2");
        drain("sparse2");
        issue(1, 1'b0, 8'h7F, 8'h01, 8'h80, "sparse1");
        drain("sparse1");

        // Backpressure: 5 stalled RESP cycles, a new request waiting behind it
        rsp_ready = 1'b0;
        issue(3, 1'b1, 8'h40, 8'h01, 8'h3F, "bp");
        req_op[0] = 1'b0; req_a[7:0] = 8'h33; req_b[7:0] = 8'h44; req_valid[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 1);
            chk("bp_id", {30'd0, rsp_id}, 3);
            chk("bp_data", {24'd0, rsp_data}, 32'h3F);
            chk("bp_req_ready", {28'd0, req_ready}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_ready", {28'd0, req_ready}, 32'h1);
        chk("bp_idle", {31'd0, busy}, 0);
        if (req_ready[0]) sbq.push_back('{0, 8'h77, cyc});
        @(posedge clk); #1;
        req_valid = '0;
        drain("bp");

        // Reset during EXEC drops the operation; req0 wins afterwards over req2
        req_op[1] = 1'b0; req_a[15:8] = 8'h01; req_b[15:8] = 8'h02;
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("rx_hs", {28'd0, req_ready}, 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        #2;
        reset = 1'b1;
        sbq.delete();
        #1;
        chk("rx_busy", {31'd0, busy}, 0);
        chk("rx_alu_a", {24'd0, alu_a}, 0);
        chk("rx_alu_b", {24'd0, alu_b}, 0);
        chk("rx_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rx_rsp_id", {30'd0, rsp_id}, 0);
        req_op[0] = 1'b1; req_a[7:0] = 8'h0A; req_b[7:0] = 8'h03;
        req_op[2] = 1'b0; req_a[23:16] = 8'h11; req_b[23:16] = 8'h22;
        req_valid = 4'b0101;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rx_grant0", {28'd0, req_ready}, 32'h1);
        if (req_ready[0]) sbq.push_back('{0, 8'h07, cyc});
        @(posedge clk); #1;
        req_valid = '0;
        drain("rx");

        // Fairness from a fresh reset: grants 0,1,2,3,0,1 every 4 cycles
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        req_op = 4'b1010;
        req_a  = {8'h07, 8'h80, 8'h50, 8'h20};
        req_b  = {8'h07, 8'h90, 8'h60, 8'h22};
        @(posedge clk); #1;
        req_valid = 4'hF;
        k = 0; n = 0; last = 0;
        while (k < 6 && n < 60) begin
            @(negedge clk);
            n++;
            if (req_ready != 4'h0) begin
                chk("fair_grant", {28'd0, req_ready}, 32'(1) << seq[k]);
                if (k > 0) chk("fair_spacing", cyc - last, 4);
                last = cyc;
                sbq.push_back('{seq[k], fexp[seq[k]], cyc});
                k++;
            end
        end
        chk("fair_count", k, 6);
        @(posedge clk); #1;
        req_valid = '0;
        drain("fair");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
